// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war match sequencer.
package tow_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        ARMED,
        RESULT,
        DONE
    } state_e;

    localparam int   SCORE_W_DEF = 3;
    localparam logic LEFT        = 1'b0;
    localparam logic RIGHT       = 1'b1;

endpackage

// File: rtl/tick_timer.sv
// Down-counter paced by slowen; expire fires on the tick that would take it from 1 to 0.
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         slowen,
    output logic         expire
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (slowen && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expire = slowen && (cnt_q == W'(1));

endmodule

// File: rtl/match_sequencer.sv
// Best-of-N match controller: random pre-arm wait, armed window, round attribution,
// result display and match completion, on top of the existing push/LED datapath.
module match_sequencer
    import tow_pkg::*;
#(
    parameter int WIN_ROUNDS = 3,
    parameter int DELAY_MIN  = 4,
    parameter int DELAY_BITS = 3,
    parameter int SHOW_TICKS = 8,
    parameter int SCORE_W    = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               slowen,
    input  logic               rand_i,
    input  logic               start,
    input  logic               sypush,
    input  logic               right,
    input  logic               tie,
    output logic               leds_on,
    output logic               clear,
    output logic               winrnd,
    output logic               round_right,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               match_over,
    output logic               match_winner
);

    localparam int TW = $clog2(DELAY_MIN + 2**DELAY_BITS + SHOW_TICKS);
    localparam logic [TW-1:0]      SHOW_LOAD = TW'(SHOW_TICKS);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_ROUNDS);

    state_e                state_q, state_d;
    logic [DELAY_BITS-1:0] rnd_q;
    logic [SCORE_W-1:0]    score_l_q, score_l_d, score_r_q, score_r_d;
    logic                  clear_q, clear_d;
    logic                  winrnd_q, winrnd_d;
    logic                  rr_q, rr_d;
    logic                  tmr_load, tmr_exp;
    logic [TW-1:0]         tmr_val, delay_load;
    logic                  match_won;

    assign delay_load = TW'(DELAY_MIN) + TW'(rnd_q);
    assign match_won  = (score_l_q == WIN) || (score_r_q == WIN);

    tick_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .slowen   (slowen),
        .expire   (tmr_exp)
    );

    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        clear_d   = 1'b0;
        winrnd_d  = 1'b0;
        rr_d      = rr_q;
        tmr_load  = 1'b0;
        tmr_val   = delay_load;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = DELAY;
                    tmr_load = 1'b1;
                    clear_d  = 1'b1;
                end
            end
            DELAY: begin
                // A push before the LEDs arm is a false start, even on the expiry tick.
                if (sypush) begin
                    state_d  = RESULT;
                    tmr_load = 1'b1;
                    tmr_val  = SHOW_LOAD;
                    if (!tie) begin
                        winrnd_d = 1'b1;
                        rr_d     = ~right;
                    end
                end else if (tmr_exp) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (sypush) begin
                    state_d  = RESULT;
                    tmr_load = 1'b1;
                    tmr_val  = SHOW_LOAD;
                    if (!tie) begin
                        winrnd_d = 1'b1;
                        rr_d     = right;
                    end
                end
            end
            RESULT: begin
                if (tmr_exp) begin
                    if (match_won) begin
                        state_d = DONE;
                    end else begin
                        state_d  = DELAY;
                        tmr_load = 1'b1;
                        clear_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = DELAY;
                    tmr_load  = 1'b1;
                    clear_d   = 1'b1;
                    score_l_d = '0;
                    score_r_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturate at WIN_ROUNDS so a counter can never wrap.
        if (winrnd_d) begin
            if (rr_d == RIGHT) begin
                if (score_r_q != WIN) score_r_d = score_r_q + SCORE_W'(1);
            end else if (rr_d == LEFT) begin
                if (score_l_q != WIN) score_l_d = score_l_q + SCORE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rnd_q     <= '0;
            score_l_q <= '0;
            score_r_q <= '0;
            clear_q   <= 1'b0;
            winrnd_q  <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= DELAY_BITS'({rnd_q, rand_i});
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            clear_q   <= clear_d;
            winrnd_q  <= winrnd_d;
            rr_q      <= rr_d;
        end
    end

    assign leds_on      = (state_q == ARMED);
    assign clear        = clear_q;
    assign winrnd       = winrnd_q;
    assign round_right  = rr_q;
    assign score_l      = score_l_q;
    assign score_r      = score_r_q;
    assign match_over   = (state_q == DONE);
    assign match_winner = match_over && (score_r_q == WIN);

endmodule

// File: tb/tb_match_sequencer.sv
// Round-table driven bench for match_sequencer with a small round-result scoreboard.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       rst, slowen, rand_b, start, sypush, right, tie;
    logic       leds_on, clear, winrnd, round_right, match_over, match_winner;
    logic [2:0] score_l, score_r;

    always #5 clk = ~clk;

    match_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .slowen       (slowen),
        .rand_i       (rand_b),
        .start        (start),
        .sypush       (sypush),
        .right        (right),
        .tie          (tie),
        .leds_on      (leds_on),
        .clear        (clear),
        .winrnd       (winrnd),
        .round_right  (round_right),
        .score_l      (score_l),
        .score_r      (score_r),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int leds_cnt = 0;

    always @(negedge clk) begin
        if (clear)   clr_cnt  <= clr_cnt + 1;
        if (leds_on) leds_cnt <= leds_cnt + 1;
    end

    // kind: 0 = push early in DELAY, 1 = push while ARMED, 2 = push on the final DELAY tick
    typedef struct {
        int   kind;
        logic r;
        logic t;
        logic ewin;
        logic err;
        int   el;
        int   er;
        logic eleds;
    } vec_t;

    typedef struct {
        logic win;
        logic rr;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic p, input logic r, input logic t, input logic st);
        slowen = s; sypush = p; right = r; tie = t; start = st;
        @(posedge clk);
        #1;
        slowen = 1'b0; sypush = 1'b0; right = 1'b0; tie = 1'b0; start = 1'b0;
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic play(input int idx, input vec_t v, input bit last);
        int   c0, l0;
        exp_t e;
        c0 = clr_cnt;
        l0 = leds_cnt;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (v.kind == 0 ? 2 : (v.kind == 1 ? 4 : 3)) tick();
        if (v.kind == 1) chk($sformatf("row%0d leds_armed", idx), leds_on, 1);
        sbq.push_back('{v.ewin, v.err});
        step(v.kind == 2, 1'b1, v.r, v.t, 1'b0);
        e = sbq.pop_front();
        chk($sformatf("row%0d winrnd", idx), winrnd, e.win);
        if (e.win) chk($sformatf("row%0d round_right", idx), round_right, e.rr);
        chk($sformatf("row%0d leds_drop", idx), leds_on, 0);
        chk($sformatf("row%0d score_l", idx), score_l, v.el);
        chk($sformatf("row%0d score_r", idx), score_r, v.er);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk($sformatf("row%0d winrnd_pulse", idx), winrnd, 0);
        chk($sformatf("row%0d leds_seen", idx), int'(leds_cnt != l0), v.eleds);
        repeat (7) tick();
        chk($sformatf("row%0d clear_in_show", idx), clr_cnt - c0, 0);
        tick();
        chk($sformatf("row%0d clear_next", idx), clr_cnt - c0, last ? 0 : 1);
        chk($sformatf("row%0d match_over", idx), match_over, int'(last));
    endtask

    initial begin
        tbl[0] = '{1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 1'b1};
        tbl[1] = '{0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 2, 1'b0};
        tbl[2] = '{1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 2, 1'b1};
        tbl[3] = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 2, 1'b1};
        tbl[4] = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 2, 2, 1'b0};
        tbl[5] = '{0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 2, 1'b0};
        tbl[6] = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 2, 1'b1};
        tbl[7] = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 1'b1};
        tbl[8] = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0, 1'b1};
        tbl[9] = '{1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1, 1'b1};

        rst = 1'b1; rand_b = 1'b0;
        slowen = 1'b0; sypush = 1'b0; right = 1'b0; tie = 1'b0; start = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst leds_on", leds_on, 0);
        chk("rst clear", clear, 0);
        chk("rst winrnd", winrnd, 0);
        chk("rst round_right", round_right, 0);
        chk("rst score_l", score_l, 0);
        chk("rst score_r", score_r, 0);
        chk("rst match_over", match_over, 0);
        chk("rst match_winner", match_winner, 0);
        rst = 1'b0;

        // Pushes and ticks in IDLE do nothing.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle winrnd", winrnd, 0);
        chk("idle score_r", score_r, 0);
        repeat (5) tick();
        chk("idle leds", leds_cnt, 0);
        chk("idle clear", clr_cnt, 0);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("start clear", clear, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("start clear_once", clear, 0);
        chk("start clear_cnt", clr_cnt, 1);

        for (int i = 0; i < 10; i++) begin
            play(i, tbl[i], i == 6);
            if (i == 6) begin
                chk("done match_over", match_over, 1);
                chk("done match_winner", match_winner, 0);
                chk("done score_l", score_l, 3);
                chk("done score_r", score_r, 2);
                step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("done push winrnd", winrnd, 0);
                chk("done push score_r", score_r, 2);
                chk("done push match_over", match_over, 1);
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                chk("restart score_l", score_l, 0);
                chk("restart score_r", score_r, 0);
                chk("restart match_over", match_over, 0);
                chk("restart clear", clear, 1);
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        // Reset while armed with scores 2/1.
        repeat (4) tick();
        chk("pre-rst leds_on", leds_on, 1);
        chk("pre-rst score_l", score_l, 2);
        chk("pre-rst score_r", score_r, 1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("midrst leds_on", leds_on, 0);
        chk("midrst clear", clear, 0);
        chk("midrst winrnd", winrnd, 0);
        chk("midrst round_right", round_right, 0);
        chk("midrst score_l", score_l, 0);
        chk("midrst score_r", score_r, 0);
        chk("midrst match_over", match_over, 0);
        chk("midrst match_winner", match_winner, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("postrst winrnd", winrnd, 0);
        chk("postrst score_r", score_r, 0);
        begin
            int l0;
            l0 = leds_cnt;
            repeat (6) tick();
            chk("postrst leds", leds_cnt - l0, 0);
        end

        // Full random extra wait: shift register all ones gives DELAY_MIN+7 ticks.
        rand_b = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        rand_b = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (10) tick();
        chk("maxdelay leds_early", leds_on, 0);
        tick();
        chk("maxdelay leds_armed", leds_on, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
